// File: rtl/ps2_key_decoder_if.sv
// Byte-stream input and decoded command outputs of the PS/2 key decoder.
// The master side is the PS/2 receiver / cursor controller pair; the slave side is the decoder.
interface ps2_key_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       up_pulse;
    logic       down_pulse;
    logic       left_pulse;
    logic       right_pulse;
    logic       select_pulse;
    logic [4:0] key_held;
    logic [7:0] last_code;
    logic       seq_error;

    modport master (
        output rx_data, rx_valid,
        input  up_pulse, down_pulse, left_pulse, right_pulse, select_pulse,
        input  key_held, last_code, seq_error
    );

    modport slave (
        input  rx_data, rx_valid,
        output up_pulse, down_pulse, left_pulse, right_pulse, select_pulse,
        output key_held, last_code, seq_error
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks F0/E0 prefixes, emits one-cycle cursor command pulses and held flags.
// Optional KEY_AUTOREPEAT_EN: a repeated make of a held key re-fires its pulse (typematic stepping).
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clock,
    input  logic                 reset,
    ps2_key_decoder_if.slave     bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [4:0]       pulse_r, pulse_s;
    logic [4:0]       held_r, held_s;
    logic [7:0]       last_r, last_s;
    logic             err_r, err_s;
    logic             done_s, ext_s, brk_s, prefix_s;
    logic [4:0]       key_s;

    // One-hot {select,right,left,down,up} for a completed code; aliases share a bit.
    function automatic logic [4:0] map_key(input logic ext, input logic [7:0] code);
        logic [4:0] k;
        k = 5'b00000;
        if (ext) begin
            case (code)
                8'h75:   k = 5'b00001;
                8'h72:   k = 5'b00010;
                8'h6B:   k = 5'b00100;
                8'h74:   k = 5'b01000;
                default: k = 5'b00000;
            endcase
        end else begin
            case (code)
                8'h1D:   k = 5'b00001;
                8'h1B:   k = 5'b00010;
                8'h1C:   k = 5'b00100;
                8'h23:   k = 5'b01000;
                8'h22:   k = 5'b10000;
                default: k = 5'b00000;
            endcase
        end
        return k;
    endfunction

    // Next-state, timeout and output computation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = (state_r == IDLE) ? CNT_W'(0) : cnt_r + CNT_W'(1);
        pulse_s  = 5'b00000;
        held_s   = held_r;
        last_s   = last_r;
        err_s    = 1'b0;
        done_s   = 1'b0;
        ext_s    = 1'b0;
        brk_s    = 1'b0;
        prefix_s = (bus.rx_data == BRK_CODE) || (bus.rx_data == EXT_CODE);

        if (bus.rx_valid) begin
            cnt_s = CNT_W'(0);
            case (state_r)
                IDLE: begin
                    if (bus.rx_data == BRK_CODE) begin
                        state_s = BRK;
                    end else if (bus.rx_data == EXT_CODE) begin
                        state_s = EXT;
                    end else begin
                        done_s = 1'b1;
                    end
                end
                EXT: begin
                    if (bus.rx_data == BRK_CODE) begin
                        state_s = EXT_BRK;
                    end else if (bus.rx_data == EXT_CODE) begin
                        state_s = EXT;
                    end else begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                        ext_s   = 1'b1;
                    end
                end
                BRK: begin
                    state_s = IDLE;
                    done_s  = !prefix_s;
                    brk_s   = 1'b1;
                end
                EXT_BRK: begin
                    state_s = IDLE;
                    done_s  = !prefix_s;
                    ext_s   = 1'b1;
                    brk_s   = 1'b1;
                end
                default: state_s = IDLE;
            endcase
        end else if ((state_r != IDLE) && (cnt_r == CNT_TERM)) begin
            state_s = IDLE;
            cnt_s   = CNT_W'(0);
            err_s   = 1'b1;
        end else begin
            state_s = state_r;
        end

        key_s = map_key(ext_s, bus.rx_data);

        // A break only clears; a make pulses on the first press (or every press with autorepeat).
        if (done_s) begin
            last_s = bus.rx_data;
            if (brk_s) begin
                held_s = held_r & ~key_s;
            end else if ((held_r & key_s) == 5'b00000) begin
                held_s  = held_r | key_s;
                pulse_s = key_s;
            end else begin
`ifdef KEY_AUTOREPEAT_EN
                pulse_s = key_s;
`else
                pulse_s = 5'b00000;
`endif
            end
        end else begin
            last_s = last_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_W'(0);
            pulse_r <= 5'b00000;
            held_r  <= 5'b00000;
            last_r  <= 8'h00;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pulse_r <= pulse_s;
            held_r  <= held_s;
            last_r  <= last_s;
            err_r   <= err_s;
        end
    end

    assign bus.up_pulse     = pulse_r[0];
    assign bus.down_pulse   = pulse_r[1];
    assign bus.left_pulse   = pulse_r[2];
    assign bus.right_pulse  = pulse_r[3];
    assign bus.select_pulse = pulse_r[4];
    assign bus.key_held     = held_r;
    assign bus.last_code    = last_r;
    assign bus.seq_error    = err_r;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a prefix-flag reference model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
    localparam int T = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   check_en = 1'b0;

    ps2_key_decoder_if bus();
    ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    // Reference model: pending prefix is remembered as "ext seen" / "break seen" flags.
    logic [4:0] exp_pulse = 5'b0, exp_held = 5'b0;
    logic [7:0] exp_last = 8'h00;
    logic       exp_err = 1'b0;
    bit         p_pend = 0, p_ext = 0, p_brk = 0;
    int         age = 0;

    function automatic int key_index(bit ext, logic [7:0] c);
        if (ext) return (c == 8'h75) ? 0 : (c == 8'h72) ? 1 : (c == 8'h6B) ? 2 : (c == 8'h74) ? 3 : -1;
        return (c == 8'h1D) ? 0 : (c == 8'h1B) ? 1 : (c == 8'h1C) ? 2 : (c == 8'h23) ? 3 : (c == 8'h22) ? 4 : -1;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [7:0] d);
        int k;
        exp_pulse = 5'b0;
        exp_err = 1'b0;
        if (r) begin
            exp_held = 5'b0; exp_last = 8'h00;
            p_pend = 0; p_ext = 0; p_brk = 0; age = 0;
        end else if (v) begin
            age = 0;
            if (d == 8'hF0 || d == 8'hE0) begin
                if (p_brk) begin
                    p_pend = 0; p_ext = 0; p_brk = 0;
                end else begin
                    p_pend = 1;
                    if (d == 8'hF0) p_brk = 1; else p_ext = 1;
                end
            end else begin
                exp_last = d;
                k = key_index(p_ext, d);
                if (k >= 0) begin
                    if (p_brk) exp_held[k] = 1'b0;
                    else if (!exp_held[k]) begin
                        exp_held[k] = 1'b1; exp_pulse[k] = 1'b1;
                    end else begin
`ifdef KEY_AUTOREPEAT_EN
                        exp_pulse[k] = 1'b1;
`endif
                    end
                end
                p_pend = 0; p_ext = 0; p_brk = 0;
            end
        end else if (p_pend) begin
            if (age == T - 1) begin
                p_pend = 0; p_ext = 0; p_brk = 0; age = 0; exp_err = 1'b1;
            end else begin
                age++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clock) begin
        #1;
        if (check_en) begin
            chk("pulses", {27'd0, bus.select_pulse, bus.right_pulse, bus.left_pulse, bus.down_pulse, bus.up_pulse},
                {27'd0, exp_pulse});
            chk("key_held", {27'd0, bus.key_held}, {27'd0, exp_held});
            chk("last_code", {24'd0, bus.last_code}, {24'd0, exp_last});
            chk("seq_error", {31'd0, bus.seq_error}, {31'd0, exp_err});
        end
    end

    task automatic cycle(input bit v, input logic [7:0] d, input bit r);
        @(negedge clock);
        reset = r;
        bus.rx_valid = v;
        bus.rx_data = d;
        model_step(r, v, d);
        @(posedge clock);
        #2;
        check_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int n;
        logic [7:0] pool [12];
        pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h22, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hE0, 8'h5A};
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;

        cycle(1'b0, 8'h00, 1'b1);
        chk("reset_held", {27'd0, bus.key_held}, 32'h0);
        chk("reset_last", {24'd0, bus.last_code}, 32'h0);

        cycle(1'b1, 8'h1D, 1'b0);
        chk("up_make_pulse", {31'd0, bus.up_pulse}, 32'd1);
        chk("up_make_held", {27'd0, bus.key_held}, 32'b00001);
        chk("up_make_last", {24'd0, bus.last_code}, 32'h1D);
        idle(1);
        chk("up_pulse_one_cycle", {31'd0, bus.up_pulse}, 32'd0);

        cycle(1'b1, 8'h1D, 1'b0);
`ifdef KEY_AUTOREPEAT_EN
        chk("repeat_make", {31'd0, bus.up_pulse}, 32'd1);
`else
        chk("repeat_make", {31'd0, bus.up_pulse}, 32'd0);
`endif
        cycle(1'b1, 8'hF0, 1'b0);
        cycle(1'b1, 8'h1D, 1'b0);
        chk("break_no_pulse", {31'd0, bus.up_pulse}, 32'd0);
        chk("break_held", {27'd0, bus.key_held}, 32'd0);
        chk("break_last", {24'd0, bus.last_code}, 32'h1D);

        cycle(1'b1, 8'hE0, 1'b0);
        chk("e0_no_pulse", {31'd0, bus.up_pulse}, 32'd0);
        cycle(1'b1, 8'h75, 1'b0);
        chk("ext_up_pulse", {31'd0, bus.up_pulse}, 32'd1);
        cycle(1'b1, 8'hE0, 1'b0);
        cycle(1'b1, 8'hF0, 1'b0);
        cycle(1'b1, 8'h75, 1'b0);
        chk("ext_break_held", {27'd0, bus.key_held}, 32'd0);

        cycle(1'b1, 8'hF0, 1'b0);
        idle(T - 1);
        chk("no_early_timeout", {31'd0, bus.seq_error}, 32'd0);
        idle(1);
        chk("timeout_err", {31'd0, bus.seq_error}, 32'd1);
        cycle(1'b1, 8'h22, 1'b0);
        chk("select_after_timeout", {31'd0, bus.select_pulse}, 32'd1);

        cycle(1'b1, 8'hF0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h23, 1'b0);
        chk("right_after_reset", {31'd0, bus.right_pulse}, 32'd1);
        chk("right_held", {27'd0, bus.key_held}, 32'b01000);

        cycle(1'b1, 8'h5A, 1'b0);
        chk("unmapped_last", {24'd0, bus.last_code}, 32'h5A);
        chk("unmapped_held", {27'd0, bus.key_held}, 32'b01000);

        // Byte arriving exactly at terminal count completes the break instead of timing out.
        cycle(1'b1, 8'hF0, 1'b0);
        idle(T - 1);
        cycle(1'b1, 8'h23, 1'b0);
        chk("terminal_byte_err", {31'd0, bus.seq_error}, 32'd0);
        chk("terminal_byte_held", {27'd0, bus.key_held}, 32'd0);

        for (int i = 0; i < 4000; i++) begin
            n = $urandom_range(0, 99);
            if (n < 1) cycle(1'b0, 8'h00, 1'b1);
            else if (n < 3) idle($urandom_range(T - 2, T + 2));
            else if (n < 40) cycle(1'b1, pool[$urandom_range(0, 11)], 1'b0);
            else if (n < 43) cycle(1'b1, 8'($urandom), 1'b0);
            else cycle(1'b0, 8'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
